fir_alu_sequencer: RTL

Sequences the shared 16-bit fixed-point ALU (sel=1 multiply, sel=0 add; 32-bit out) through an N-tap direct-form FIR computation. Each accepted input sample costs one multiply/add pair per tap.
- Holds the sample delay line and the coefficient bank.
- Drives the ALU operand and select ports, and collects results.
- Emits one filtered Q4.11 sample per accepted input via valid/ready handshakes.

---
 rtl/fir_alu_sequencer_if.sv | 37 +++
 rtl/fir_alu_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fir_alu_sequencer_if.sv
// Stream, coefficient-port and shared-ALU signals of the FIR sequencer.
// master = sequencer side, slave = environment (sources, sink, ALU).
interface fir_alu_sequencer_if #(
    parameter int N  = 16,
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_data;
    logic          busy;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic          alu_sel;
    logic [31:0]   alu_out;

    modport master (
        input  in_valid, in_data, out_ready,
        input  coef_we, coef_addr, coef_data,
        input  alu_out,
        output in_ready, out_valid, out_data,
        output busy, alu_a, alu_b, alu_sel
    );

    modport slave (
        output in_valid, in_data, out_ready,
        output coef_we, coef_addr, coef_data,
        output alu_out,
        input  in_ready, out_valid, out_data,
        input  busy, alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/fir_alu_sequencer.sv
// Direct-form FIR sequencer driving a shared 16-bit fixed-point ALU.
// One multiply/add pair per tap; one Q4.11 result per accepted sample.
module fir_alu_sequencer #(
    parameter int N    = 16,
    parameter int TAPS = 16,
    parameter int AW   = 4
) (
    input logic clk,
    input logic rst_n,
    fir_alu_sequencer_if.master bus
);
    localparam int IW   = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int FRAC = N - 5;
    localparam int MAXV = (1 << (N - 1)) - 1;
    localparam int MINV = -(1 << (N - 1));

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        DONE
    } state_e;

    state_e state_q, state_d;
    logic [IW-1:0] head_q, head_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] tap_idx;
    logic signed [N-1:0] acc_q, acc_d;
    logic signed [N-1:0] prod_q, prod_d;
    logic signed [N-1:0] dline_q [TAPS];
    logic signed [N-1:0] dline_d [TAPS];
    logic signed [N-1:0] coef_q [TAPS];
    logic signed [N-1:0] coef_d [TAPS];
    logic coef_hit;
    logic signed [31:0] alu_s;

    function automatic logic signed [N-1:0] sat(
        input logic signed [31:0] v
    );
        logic signed [N-1:0] r;
        if (v > MAXV) begin
            r = N'(MAXV);
        end else if (v < MINV) begin
            r = N'(MINV);
        end else begin
            r = v[N-1:0];
        end
        return r;
    endfunction

    assign alu_s = $signed(bus.alu_out);

    // x[n-k] lives at (head-k) mod TAPS; the mod-2^IW arithmetic
    // still lands in range because the true result is < TAPS.
    always_comb begin
        if (head_q >= k_q) begin
            tap_idx = head_q - k_q;
        end else begin
            tap_idx = head_q + IW'(TAPS) - k_q;
        end
    end

    assign coef_hit = bus.coef_we && (state_q == IDLE)
                   && (32'(bus.coef_addr) < TAPS);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        k_d     = k_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        dline_d = dline_q;
        coef_d  = coef_q;
        if (coef_hit) begin
            coef_d[bus.coef_addr[IW-1:0]] = bus.coef_data;
        end
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dline_d[head_q] = bus.in_data;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d  = sat(alu_s >>> FRAC);
                state_d = ADD;
            end
            ADD: begin
                acc_d = sat(alu_s);
                if (k_q == IW'(TAPS - 1)) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + IW'(1);
                    state_d = MUL;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (head_q == IW'(TAPS - 1)) begin
                        head_d = '0;
                    end else begin
                        head_d = head_q + IW'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b1;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_sel   = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            MUL: begin
                bus.alu_sel = 1'b1;
                bus.alu_a   = dline_q[tap_idx];
                bus.alu_b   = coef_q[k_q];
            end
            ADD: begin
                bus.alu_a = acc_q;
                bus.alu_b = prod_q;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc_q;
            end
            default: bus.busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            dline_q <= '{default: '0};
            coef_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            dline_q <= dline_d;
            coef_q  <= coef_d;
        end
    end
endmodule
